dcache_assoc: RTL and testbench

DCACHE_ASSOC -- requirements
Module: dcache_assoc

---
 rtl/dcache_assoc.sv | 163 ++++++++++++++++
 tb/tb_dcache_assoc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// 2-way set-associative write-back, write-allocate data cache with one LRU bit per set.
// Define DCACHE_STATS_EN to add the HIT_COUNT / MISS_COUNT statistics outputs.
module dcache_assoc #(
   parameter int SETS  = 8,
   parameter int WORDS = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        MEM_READ,
   input  logic                        MEM_WRITE,
   input  logic [31:0]                 MEM_ADDRESS,
   input  logic [3:0]                  BYTE_EN,
   input  logic [31:0]                 DATA_IN,
   output logic [31:0]                 CACHE_READ_OUT,
   output logic                        BUSYWAIT,
   output logic                        MEM_MEM_READ,
   output logic                        MEM_MEM_WRITE,
   output logic [29-$clog2(WORDS):0]   MEM_BLOCK_ADDR,
   output logic [32*WORDS-1:0]         MEM_WRITE_OUT,
   input  logic [32*WORDS-1:0]         MEM_READ_OUT,
   input  logic                        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,output logic [31:0]                 HIT_COUNT,
   output logic [31:0]                 MISS_COUNT
`endif
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int OFF_WX = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_W  = $clog2(SETS);
   localparam int BLK_W  = 30 - OFF_W;
   localparam int TAG_W  = BLK_W - IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
   state_t state;

   logic [TAG_W-1:0]     tag_q  [2][SETS];
   logic [32*WORDS-1:0]  data_q [2][SETS];
   logic [SETS-1:0]      valid_q [2];
   logic [SETS-1:0]      dirty_q [2];
   logic [SETS-1:0]      lru_q;
   logic                 vic_q;
   logic [BLK_W-1:0]     miss_blk;

   logic                 access, hit, hit_way, victim, vic_dirty;
   logic [1:0]           way_hit;
   logic [BLK_W-1:0]     addr_blk;
   logic [IDX_W-1:0]     idx, miss_idx;
   logic [TAG_W-1:0]     tag, miss_tag;
   logic [OFF_WX-1:0]    off;
   logic [31:0]          hit_word, wr_word;
   logic                 addr_unused;

   assign addr_blk    = MEM_ADDRESS[31:2+OFF_W];
   assign idx         = addr_blk[IDX_W-1:0];
   assign tag         = addr_blk[BLK_W-1:IDX_W];
   assign off         = (WORDS == 1) ? '0 : MEM_ADDRESS[2 +: OFF_WX];
   assign miss_idx    = miss_blk[IDX_W-1:0];
   assign miss_tag    = miss_blk[BLK_W-1:IDX_W];
   assign addr_unused = ^MEM_ADDRESS[1:0];

   always_comb begin
      access     = MEM_READ | MEM_WRITE;
      way_hit[0] = access && (state == IDLE) && valid_q[0][idx] && (tag_q[0][idx] == tag);
      way_hit[1] = access && (state == IDLE) && valid_q[1][idx] && (tag_q[1][idx] == tag);
      hit        = |way_hit;
      hit_way    = way_hit[1];
      // Fill invalid ways in order before falling back to LRU replacement
      victim     = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
      vic_dirty  = valid_q[victim][idx] & dirty_q[victim][idx];
      hit_word   = data_q[hit_way][idx][{off, 5'b0} +: 32];
      wr_word    = hit_word;
      for (int unsigned b = 0; b < 4; b++)
         if (BYTE_EN[b]) wr_word[8*b +: 8] = DATA_IN[8*b +: 8];
      CACHE_READ_OUT = hit ? hit_word : '0;
      BUSYWAIT       = RESET & ((state != IDLE) | (access & ~hit));
   end

   // Tag and data arrays carry no reset; the valid bits gate every use of them
   always_ff @(posedge CLK) begin
      if (state == IDLE && hit && MEM_WRITE)
         data_q[hit_way][idx][{off, 5'b0} +: 32] <= wr_word;
      if (state == UPDATE) begin
         tag_q[vic_q][miss_idx]  <= miss_tag;
         data_q[vic_q][miss_idx] <= MEM_READ_OUT;
      end
   end

`ifdef DCACHE_STATS_EN
   logic after_upd;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= IDLE;
         valid_q        <= '{default: '0};
         dirty_q        <= '{default: '0};
         lru_q          <= '0;
         vic_q          <= 1'b0;
         miss_blk       <= '0;
         MEM_MEM_READ   <= 1'b0;
         MEM_MEM_WRITE  <= 1'b0;
         MEM_BLOCK_ADDR <= '0;
         MEM_WRITE_OUT  <= '0;
`ifdef DCACHE_STATS_EN
         after_upd      <= 1'b0;
         HIT_COUNT      <= '0;
         MISS_COUNT     <= '0;
`endif
      end else begin
`ifdef DCACHE_STATS_EN
         after_upd <= (state == UPDATE);
`endif
         case (state)
            IDLE: begin
               if (hit) begin
                  lru_q[idx] <= ~hit_way;
                  if (MEM_WRITE) dirty_q[hit_way][idx] <= 1'b1;
`ifdef DCACHE_STATS_EN
                  if (!after_upd) HIT_COUNT <= HIT_COUNT + 32'd1;
`endif
               end else if (access) begin
                  vic_q    <= victim;
                  miss_blk <= addr_blk;
`ifdef DCACHE_STATS_EN
                  MISS_COUNT <= MISS_COUNT + 32'd1;
`endif
                  if (vic_dirty) begin
                     state          <= WRITEBACK;
                     MEM_MEM_WRITE  <= 1'b1;
                     MEM_BLOCK_ADDR <= {tag_q[victim][idx], idx};
                     MEM_WRITE_OUT  <= data_q[victim][idx];
                  end else begin
                     state          <= FETCH;
                     MEM_MEM_READ   <= 1'b1;
                     MEM_BLOCK_ADDR <= addr_blk;
                  end
               end
            end
            WRITEBACK: if (!MEM_BUSYWAIT) begin
               state          <= FETCH;
               MEM_MEM_WRITE  <= 1'b0;
               MEM_WRITE_OUT  <= '0;
               MEM_MEM_READ   <= 1'b1;
               MEM_BLOCK_ADDR <= miss_blk;
            end
            FETCH: if (!MEM_BUSYWAIT) begin
               state          <= UPDATE;
               MEM_MEM_READ   <= 1'b0;
               MEM_BLOCK_ADDR <= '0;
            end
            UPDATE: begin
               state                    <= IDLE;
               valid_q[vic_q][miss_idx] <= 1'b1;
               dirty_q[vic_q][miss_idx] <= 1'b0;
               lru_q[miss_idx]          <= ~vic_q;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: flat-memory + tag-recency reference model, randomized accesses,
// a backing-memory responder with random latency, and a few literal directed checks.
module tb_dcache_assoc;
   localparam int SETS  = 8;
   localparam int WORDS = 4;

   logic         CLK = 1'b0;
   logic         RESET, MEM_READ, MEM_WRITE, BUSYWAIT, MEM_MEM_READ, MEM_MEM_WRITE, MEM_BUSYWAIT;
   logic [31:0]  MEM_ADDRESS, DATA_IN, CACHE_READ_OUT;
   logic [3:0]   BYTE_EN;
   logic [27:0]  MEM_BLOCK_ADDR;
   logic [127:0] MEM_WRITE_OUT, MEM_READ_OUT;
`ifdef DCACHE_STATS_EN
   logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

   dcache_assoc #(.SETS(SETS), .WORDS(WORDS)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDRESS(MEM_ADDRESS), .BYTE_EN(BYTE_EN), .DATA_IN(DATA_IN),
      .CACHE_READ_OUT(CACHE_READ_OUT), .BUSYWAIT(BUSYWAIT),
      .MEM_MEM_READ(MEM_MEM_READ), .MEM_MEM_WRITE(MEM_MEM_WRITE),
      .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR), .MEM_WRITE_OUT(MEM_WRITE_OUT),
      .MEM_READ_OUT(MEM_READ_OUT), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
     ,.HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   int total = 0, bad = 0;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Backing memory (block granular) and CPU-visible memory (word granular)
   logic [127:0] bmem [int unsigned];
   logic [31:0]  gold [int unsigned];

   function automatic logic [31:0] init_word(int unsigned w);
      return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] bmem_word(int unsigned w);
      logic [127:0] b;
      if (bmem.exists(w / 4)) begin
         b = bmem[w / 4];
         return b[(w % 4) * 32 +: 32];
      end
      return init_word(w);
   endfunction

   function automatic logic [31:0] gold_word(int unsigned w);
      return gold.exists(w) ? gold[w] : bmem_word(w);
   endfunction

   function automatic logic [127:0] gold_block(int unsigned blk);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = gold_word(blk * 4 + i);
      return r;
   endfunction

   function automatic logic [127:0] bmem_block(int unsigned blk);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = bmem_word(blk * 4 + i);
      return r;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] be, logic [31:0] d);
      for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = d[b*8 +: 8];
      return old;
   endfunction

   // Per set: resident tags in recency order (index 0 = most recent)
   int unsigned m_tag [SETS][2];
   int          m_n   [SETS];
   bit          mdirty [int unsigned];
   int unsigned exp_hit, exp_miss;

   logic [31:0] ops [$];
   int          fixed_lat = 0;
   int          last_wait, last_ops;
   logic [31:0] last_wb;

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) m_n[s] = 0;
      mdirty.delete();
      gold.delete();
      ops.delete();
      exp_hit = 0;
      exp_miss = 0;
   endfunction

   // Backing memory responder
   initial begin
      int rs, cnt;
      logic [29:0]  cap_ctl;
      logic [127:0] cap_dat;
      MEM_BUSYWAIT = 1'b0;
      MEM_READ_OUT = '0;
      rs = 0; cnt = 0; cap_ctl = '0; cap_dat = '0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            rs = 0;
            MEM_BUSYWAIT = 1'b0;
         end else if (rs == 1) begin
            check("mem_req_ctl_stable", {MEM_MEM_READ, MEM_MEM_WRITE, MEM_BLOCK_ADDR}, cap_ctl);
            check("mem_req_data_stable", MEM_WRITE_OUT, cap_dat);
            cnt--;
            if (cnt == 0) begin
               MEM_BUSYWAIT = 1'b0;
               rs = 2;
               if (cap_ctl[28]) bmem[cap_ctl[27:0]] = cap_dat;
               else MEM_READ_OUT = bmem_block(cap_ctl[27:0]);
            end
         end else if (MEM_MEM_READ || MEM_MEM_WRITE) begin
            cap_ctl = {MEM_MEM_READ, MEM_MEM_WRITE, MEM_BLOCK_ADDR};
            cap_dat = MEM_WRITE_OUT;
            ops.push_back({3'b000, MEM_MEM_WRITE, MEM_BLOCK_ADDR});
            if (MEM_MEM_WRITE) check("wb_data", MEM_WRITE_OUT, gold_block(MEM_BLOCK_ADDR));
            cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            MEM_BUSYWAIT = 1'b1;
            rs = 1;
         end else begin
            rs = 0;
         end
      end
   end

   task automatic do_reset();
      @(posedge CLK);
      #1 RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      #1;
      check("rst_busy", BUSYWAIT, 0);
      check("rst_memreq", {MEM_MEM_READ, MEM_MEM_WRITE}, 0);
      check("rst_blkaddr", MEM_BLOCK_ADDR, 0);
      check("rst_wrout", MEM_WRITE_OUT, 0);
      check("rst_rdout", CACHE_READ_OUT, 0);
      model_reset();
      @(negedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b1;
   endtask

   task automatic idle_cycle();
      @(posedge CLK);
      #1 MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      @(negedge CLK);
      check("idle_busy", BUSYWAIT, 0);
      check("idle_rdout", CACHE_READ_OUT, 0);
      check("idle_memreq", {MEM_MEM_READ, MEM_MEM_WRITE}, 0);
      check("idle_blkaddr", MEM_BLOCK_ADDR, 0);
`ifdef DCACHE_STATS_EN
      check("hit_count", HIT_COUNT, exp_hit);
      check("miss_count", MISS_COUNT, exp_miss);
`endif
   endtask

   task automatic do_access(bit rd, bit wr, logic [31:0] addr, logic [3:0] be, logic [31:0] din);
      int unsigned blk = addr >> 4;
      int unsigned s   = blk % SETS;
      int unsigned tg  = blk / SETS;
      int unsigned w   = addr >> 2;
      int unsigned vblk, tmp;
      bit mhit, exp_wb;
      int kk, n, nexp;
      mhit = 0; kk = 0; exp_wb = 0; vblk = 0;
      for (int k = 0; k < m_n[s]; k++) if (m_tag[s][k] == tg) begin mhit = 1; kk = k; end
      @(posedge CLK);
      ops.delete();
      #1 MEM_READ = rd; MEM_WRITE = wr; MEM_ADDRESS = addr; BYTE_EN = be; DATA_IN = din;
      @(negedge CLK);
      check("busy_first", BUSYWAIT, !mhit);
      if (mhit) begin
         if (!wr) check("rd_hit", CACHE_READ_OUT, gold_word(w));
         exp_hit++;
         if (kk == 1) begin tmp = m_tag[s][0]; m_tag[s][0] = m_tag[s][1]; m_tag[s][1] = tmp; end
      end else begin
         check("miss_rdout_zero", CACHE_READ_OUT, 0);
         exp_miss++;
         if (m_n[s] == 2) begin
            vblk = m_tag[s][1] * SETS + s;
            exp_wb = mdirty.exists(vblk) && mdirty[vblk];
            mdirty.delete(vblk);
         end else m_n[s]++;
         m_tag[s][1] = m_tag[s][0];
         m_tag[s][0] = tg;
         n = 0;
         while (BUSYWAIT && n < 60) begin @(negedge CLK); n++; end
         check("busy_release", BUSYWAIT, 0);
         last_wait = n;
         if (!wr) check("rd_fill", CACHE_READ_OUT, gold_word(w));
         nexp = exp_wb ? 2 : 1;
         last_ops = ops.size();
         check("mem_op_count", ops.size(), nexp);
         if (ops.size() == nexp) begin
            if (exp_wb) check("wb_addr", ops[0], {4'b0001, 28'(vblk)});
            check("fetch_addr", ops[nexp-1], {4'b0000, 28'(blk)});
            last_wb = ops[0];
         end
      end
      if (wr) begin
         gold[w] = merge(gold_word(w), be, din);
         mdirty[blk] = 1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      MEM_ADDRESS = '0; BYTE_EN = '0; DATA_IN = '0;
      do_reset();
      idle_cycle();

      // Cold fill with a known block and a 3-cycle memory stall
      bmem[32'h4] = 128'h44444444_33333333_22222222_11111111;
      fixed_lat = 3;
      do_access(1, 0, 32'h40, 4'h0, 32'h0);
      check("cold_latency", last_wait, 6);
      check("cold_word_lit", CACHE_READ_OUT, 32'h11111111);
      do_access(0, 1, 32'h44, 4'b0011, 32'hDEADBEEF);
      do_access(1, 0, 32'h44, 4'h0, 32'h0);
      check("merge_lit", CACHE_READ_OUT, 32'h2222BEEF);
      idle_cycle();
`ifdef DCACHE_STATS_EN
      check("hit_count_lit", HIT_COUNT, 2);
      check("miss_count_lit", MISS_COUNT, 1);
`endif

      // Set 0 replacement: A clean, B dirty, touch A, miss C evicts B
      do_reset();
      do_access(1, 0, 32'h1000, 4'h0, 32'h0);
      do_access(0, 1, 32'h2004, 4'hF, 32'h12345678);
      do_access(1, 0, 32'h1000, 4'h0, 32'h0);
      do_access(1, 0, 32'h3000, 4'h0, 32'h0);
      check("lru_wb_ops_lit", last_ops, 2);
      check("lru_wb_addr_lit", last_wb, 32'h1000_0200);
      do_access(1, 0, 32'h2004, 4'h0, 32'h0);
      check("wb_roundtrip_lit", CACHE_READ_OUT, 32'h12345678);
      do_access(1, 1, 32'h3008, 4'hF, 32'hCAFEF00D);
      do_access(1, 0, 32'h3008, 4'h0, 32'h0);
      check("rdwr_store_lit", CACHE_READ_OUT, 32'hCAFEF00D);
      idle_cycle();

      // Reset while the fetch is outstanding
      do_reset();
      @(posedge CLK);
      #1 MEM_READ = 1'b1; MEM_WRITE = 1'b0; MEM_ADDRESS = 32'h500;
      n = 0;
      do begin @(negedge CLK); n++; end while (!MEM_MEM_READ && n < 20);
      check("fetch_seen", MEM_MEM_READ, 1);
      #2 RESET = 1'b0;
      #1;
      check("midfetch_rst_memrd", MEM_MEM_READ, 0);
      check("midfetch_rst_busy", BUSYWAIT, 0);
      MEM_READ = 1'b0;
      model_reset();
      @(negedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b1;
      do_access(1, 0, 32'h500, 4'h0, 32'h0);
      check("post_rst_miss_lit", last_ops, 1);
      idle_cycle();

      // Randomized traffic over a small address pool to force conflicts
      fixed_lat = 0;
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [31:0] a;
         if (i == 200) do_reset();
         op = int'($urandom_range(0, 9));
         a = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
         if (op == 0) idle_cycle();
         else if (op <= 5) do_access(1, 0, a, 4'h0, 32'h0);
         else if (op <= 8) do_access(0, 1, a, 4'($urandom_range(0, 15)), $urandom);
         else do_access(1, 1, a, 4'($urandom_range(0, 15)), $urandom);
      end
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
